// File: rtl/status_pkg.sv
// Shared definitions for the status-flag port arbiter: op codes, FSM states, default width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package status_pkg;

   localparam int ADDR_W_DEF = 4;

   // Operation codes; every op returns the pre-access value of the entry.
   localparam logic [1:0] OP_READ   = 2'b00;  // no write
   localparam logic [1:0] OP_WRITE  = 2'b01;  // write wdata
   localparam logic [1:0] OP_TAS    = 2'b10;  // write 1
   localparam logic [1:0] OP_TOGGLE = 2'b11;  // write inverted old value

   typedef enum logic {
      ST_SWEEP = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

endpackage

// File: rtl/status_port_arbiter_if.sv
// Bundle for the two requester ports plus the single-port status memory.
// Latency: gnt combinational in the access cycle; rdata/rvalid one cycle later.
// Backpressure: a requester holds req/op/addr/wdata until it sees its gnt bit.
// master: requesters and memory model; slave: the arbiter.
interface status_port_arbiter_if #(
   parameter int ADDR_W = status_pkg::ADDR_W_DEF
);
   logic              clear_all;
   logic [1:0]        req;
   logic [1:0]        op0;
   logic [1:0]        op1;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic              wdata0;
   logic              wdata1;
   logic [1:0]        gnt;
   logic              rdata;
   logic [1:0]        rvalid;
   logic              busy;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic              mem_din;
   logic              mem_dout;

   modport master (
      output clear_all, req, op0, op1, addr0, addr1, wdata0, wdata1, mem_dout,
      input  gnt, rdata, rvalid, busy, mem_addr, mem_we, mem_din
   );

   modport slave (
      input  clear_all, req, op0, op1, addr0, addr1, wdata0, wdata1, mem_dout,
      output gnt, rdata, rvalid, busy, mem_addr, mem_we, mem_din
   );
endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; on a tie grants the port that was not granted last.
// Latency: combinational grant; last pointer updates at the edge ending the grant.
// Backpressure: en_i low forces no grant; losers simply keep requesting.
// Ports: clk, rst (async high), req_i[1:0], en_i, gnt_o[1:0] (one-hot or zero).
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,
   input  logic       en_i,
   output logic [1:0] gnt_o
);

   // last_q = index of the most recently granted port; resets to 1 so port 0 wins the first tie.
   logic last_q;
   logic last_d;

   always_comb begin
      gnt_o = 2'b00;
      if (en_i) begin
         case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
         endcase
      end
   end

   always_comb begin
      last_d = last_q;
      if (gnt_o[0]) begin
         last_d = 1'b0;
      end else if (gnt_o[1]) begin
         last_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/status_port_arbiter.sv
// Owns the 1-bit x 2^ADDR_W status memory: zero-sweeps it after reset / clear_all, then
// grants one single-cycle READ/WRITE/TAS/TOGGLE per cycle, round-robin between two ports.
// Latency: access in the gnt cycle, rdata/rvalid one cycle later; sweep takes 2^ADDR_W cycles.
// Backpressure: gnt withheld during sweep and in a clear_all cycle; requesters hold until gnt.
// Ports: clk, rst (async high), bus (slave modport: requests, results, memory pins).
module status_port_arbiter
   import status_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input logic                 clk,
   input logic                 rst,
   status_port_arbiter_if.slave bus
);

   localparam logic [ADDR_W-1:0] CNT_LAST = '1;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              rdata_q;
   logic [1:0]        rvalid_q;

   logic [1:0]        gnt;
   logic              arb_en;
   logic [1:0]        sel_op;
   logic [ADDR_W-1:0] sel_addr;
   logic              sel_wdata;

   logic              busy;
   logic              mem_we;
   logic              mem_din;
   logic [ADDR_W-1:0] mem_addr;

   // clear_all beats requests in RUN; no grants at all while sweeping.
   assign arb_en = (state_q == ST_RUN) && !bus.clear_all;

   rr_arb2 u_arb (
      .clk   (clk),
      .rst   (rst),
      .req_i (bus.req),
      .en_i  (arb_en),
      .gnt_o (gnt)
   );

   // Port mux driven by the one-hot grant.
   assign sel_op    = gnt[1] ? bus.op1    : bus.op0;
   assign sel_addr  = gnt[1] ? bus.addr1  : bus.addr0;
   assign sel_wdata = gnt[1] ? bus.wdata1 : bus.wdata0;

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_SWEEP;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // FSM next state. The counter wraps to 0 on the last sweep cycle, ready for the next sweep.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_SWEEP: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (bus.clear_all) begin
               state_d = ST_SWEEP;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_SWEEP;
            cnt_d   = '0;
         end
      endcase
   end

   // FSM outputs and memory mux. TOGGLE inverts the combinational read of the same entry.
   always_comb begin
      busy     = 1'b0;
      mem_we   = 1'b0;
      mem_din  = 1'b0;
      mem_addr = '0;
      if (state_q == ST_SWEEP) begin
         busy     = 1'b1;
         mem_we   = 1'b1;
         mem_addr = cnt_q;
      end else if (gnt != 2'b00) begin
         mem_addr = sel_addr;
         case (sel_op)
            OP_WRITE: begin
               mem_we  = 1'b1;
               mem_din = sel_wdata;
            end
            OP_TAS: begin
               mem_we  = 1'b1;
               mem_din = 1'b1;
            end
            OP_TOGGLE: begin
               mem_we  = 1'b1;
               mem_din = ~bus.mem_dout;
            end
            default: begin
               mem_we  = 1'b0;
               mem_din = 1'b0;
            end
         endcase
      end
   end

   // Result register: captures the pre-write value seen in the grant cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q  <= 1'b0;
         rvalid_q <= 2'b00;
      end else begin
         rvalid_q <= gnt;
         if (gnt != 2'b00) begin
            rdata_q <= bus.mem_dout;
         end
      end
   end

   assign bus.gnt      = gnt;
   assign bus.rdata    = rdata_q;
   assign bus.rvalid   = rvalid_q;
   assign bus.busy     = busy;
   assign bus.mem_we   = mem_we;
   assign bus.mem_din  = mem_din;
   assign bus.mem_addr = mem_addr;

endmodule
